// File: rtl/sma_pkg.sv
// Shared types and constants for the SMA bounds-check scheduler: FSM states,
// tagged-pointer field layout and the fault_type encoding.
package sma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2,
    ST_FAULT = 2'd3
  } sma_state_e;

  localparam int BSIZE_WIDTH   = 6;
  localparam int LENGTH_WIDTH  = 4;
  localparam int BSIZE_OFFSET  = 58;
  localparam int LENGTH_OFFSET = 54;

  localparam logic [1:0] FAULT_OVERFLOW  = 2'b10;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'b01;

endpackage

// File: rtl/sma_engine.sv
// Combinational SMA bounds check: derives the segment bounds from the tagged
// pointer and clamps pointer+increment into them.
module sma_engine
  import sma_pkg::*;
#(
  parameter int WORD_WIDTH = 64
) (
  input  logic [2:0]            access_type,
  input  logic [WORD_WIDTH-1:0] tagged_pointer,
  input  logic [WORD_WIDTH-1:0] increment,
  output logic [WORD_WIDTH-1:0] sum,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  overflow,
  output logic                  underflow
);

  logic [BSIZE_WIDTH-1:0]  b_size;
  logic [LENGTH_WIDTH-1:0] l_size;
  logic [WORD_WIDTH-1:0]   ones, lower, upper, last;

  assign ones   = '1;
  assign b_size = tagged_pointer[BSIZE_OFFSET +: BSIZE_WIDTH];
  assign l_size = tagged_pointer[LENGTH_OFFSET +: LENGTH_WIDTH];
  // Shifts of 64 or more must yield zero, so the amount is kept 7 bits wide.
  assign lower  = tagged_pointer & (ones << ({1'b0, b_size} + 7'd4));
  assign upper  = lower | (WORD_WIDTH'(l_size) << b_size);
  assign last   = (upper - WORD_WIDTH'(1)) & (ones << access_type);
  assign sum    = tagged_pointer + increment;

  always_comb begin
    address   = sum;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (l_size == '0) begin
      overflow = (increment != '0);
      address  = tagged_pointer;
    end else begin
      if (sum < lower) begin
        underflow = 1'b1;
        address   = lower;
      end
      if (sum > last) begin
        overflow  = 1'b1;
        underflow = 1'b0;
        address   = last;
      end
    end
  end

endmodule

// File: rtl/sma_check_scheduler.sv
// Round-robin scheduler sharing one SMA bounds-check engine among NUM_REQ
// requesters, with a sticky first-fault record and optional halt on fault.
//
// state    | meaning
// ST_IDLE  | pick a requester, latch its operands
// ST_CHECK | engine evaluates latched operands, result registered
// ST_RESP  | result presented until resp_ready
// ST_FAULT | grants halted until fault_clear
module sma_check_scheduler
  import sma_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = 1,
  parameter int WORD_WIDTH = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [3*NUM_REQ-1:0]          req_access_type,
  input  logic [WORD_WIDTH*NUM_REQ-1:0] req_tagged_pointer,
  input  logic [WORD_WIDTH*NUM_REQ-1:0] req_increment,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [WORD_WIDTH-1:0]         resp_address,
  output logic                          resp_overflow,
  output logic                          resp_underflow,
  input  logic                          cfg_halt_on_fault,
  input  logic                          fault_clear,
  output logic                          fault_valid,
  output logic [ID_WIDTH-1:0]           fault_id,
  output logic [WORD_WIDTH-1:0]         fault_address,
  output logic [1:0]                    fault_type,
  output logic [CNT_WIDTH-1:0]          fault_count,
  output logic                          busy
);

  sma_state_e state, state_nxt;
  logic [ID_WIDTH-1:0]   rr_ptr, gnt, op_id;
  logic                  found, accept, capture;
  logic [2:0]            op_type;
  logic [WORD_WIDTH-1:0] op_ptr, op_inc, eng_sum, eng_address;
  logic                  eng_overflow, eng_underflow;
  int                    idx;

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[ID_WIDTH'(idx)]) begin
        found = 1'b1;
        gnt   = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          req_ready[gnt] = 1'b1;
          accept         = 1'b1;
          state_nxt      = ST_CHECK;
        end
      end
      ST_CHECK: state_nxt = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_nxt = ((resp_overflow || resp_underflow) && cfg_halt_on_fault) ? ST_FAULT : ST_IDLE;
      end
      ST_FAULT: if (fault_clear) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy    = (state != ST_IDLE);
  assign capture = (state == ST_CHECK) && (eng_overflow || eng_underflow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      op_id   <= '0;
      op_type <= '0;
      op_ptr  <= '0;
      op_inc  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr  <= (gnt == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt + ID_WIDTH'(1);
        op_id   <= gnt;
        op_type <= req_access_type[gnt*3 +: 3];
        op_ptr  <= req_tagged_pointer[gnt*WORD_WIDTH +: WORD_WIDTH];
        op_inc  <= req_increment[gnt*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  sma_engine #(.WORD_WIDTH(WORD_WIDTH)) u_engine (
    .access_type    (op_type),
    .tagged_pointer (op_ptr),
    .increment      (op_inc),
    .sum            (eng_sum),
    .address        (eng_address),
    .overflow       (eng_overflow),
    .underflow      (eng_underflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_id        <= '0;
      resp_address   <= '0;
      resp_overflow  <= 1'b0;
      resp_underflow <= 1'b0;
    end else if (state == ST_CHECK) begin
      resp_id        <= op_id;
      resp_address   <= eng_address;
      resp_overflow  <= eng_overflow;
      resp_underflow <= eng_underflow;
    end
  end

  // A capture coinciding with fault_clear restarts the record with this fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_valid   <= 1'b0;
      fault_id      <= '0;
      fault_address <= '0;
      fault_type    <= '0;
      fault_count   <= '0;
    end else if (capture) begin
      fault_count <= fault_clear ? CNT_WIDTH'(1) :
                     ((fault_count == '1) ? fault_count : fault_count + CNT_WIDTH'(1));
      if (!fault_valid || fault_clear) begin
        fault_valid   <= 1'b1;
        fault_id      <= op_id;
        fault_address <= eng_sum;
        fault_type    <= eng_overflow ? FAULT_OVERFLOW : FAULT_UNDERFLOW;
      end
    end else if (fault_clear) begin
      fault_valid <= 1'b0;
      fault_type  <= '0;
      fault_count <= '0;
    end
  end

endmodule

// File: doc/sma_check_scheduler.md
Name: sma_check_scheduler

Overview:
- Shares one SMA bounds-check datapath among NUM_REQ address-generation requesters (e.g. load unit, store unit).
- Round-robin arbitration and a registered check stage; returns the clamped address plus overflow/underflow flags per request.
- Captures the first bounds fault in a sticky record and can halt further grants until software clears it.
- Sits between the requesters and the LSU address port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_WIDTH, 1, requester index width, equals clog2(NUM_REQ).
- WORD_WIDTH, 64, tagged pointer / increment / address width.
- CNT_WIDTH, 8, fault counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_access_type  in  3*NUM_REQ  packed access-size log2 (slice i = requester i).
- req_tagged_pointer  in  WORD_WIDTH*NUM_REQ  packed tagged pointers.
- req_increment  in  WORD_WIDTH*NUM_REQ  packed increments.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_WIDTH  requester that owns the result.
- resp_address  out  WORD_WIDTH  checked/clamped address.
- resp_overflow  out  1  upper-bound violation.
- resp_underflow  out  1  lower-bound violation.
- cfg_halt_on_fault  in  1  enter FAULT after a faulting response.
- fault_clear  in  1  single-cycle pulse; clears the sticky record and leaves FAULT.
- fault_valid  out  1  sticky record holds a fault.
- fault_id  out  ID_WIDTH  requester that faulted.
- fault_address  out  WORD_WIDTH  unclamped pointer+increment of the faulting access.
- fault_type  out  2  {overflow, underflow}.
- fault_count  out  CNT_WIDTH  saturating count of faulting checks.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE, rr_ptr=0; every output and internal register is 0.
- FSM states: IDLE, CHECK, RESP, FAULT.
- IDLE:
  - If any req_valid and not halted, grant the first valid requester at or after rr_ptr (wrapping).
  - req_ready[grant]=1 combinationally in the same cycle; operands latch into op registers.
  - rr_ptr <= grant+1 mod NUM_REQ. Next state is CHECK.
  - With no valid request, stay in IDLE and drive req_ready=0.
- CHECK:
  - The SMA datapath evaluates the latched operands combinationally.
  - resp_address, resp_overflow and resp_underflow register at the end of the cycle; resp_id <= grant.
  - Next state is RESP.
- RESP:
  - resp_valid=1; result registers are held stable until resp_valid&&resp_ready.
  - On handshake: if (overflow|underflow) && cfg_halt_on_fault, go to FAULT; otherwise go to IDLE.
  - resp_valid drops the cycle after the handshake.
- FAULT: req_ready=0 throughout. A fault_clear pulse moves the FSM to IDLE.
- Latency and throughput: accept at cycle N, resp_valid at N+2. Peak throughput is one request per 3 cycles when resp_ready is held at 1.
- Fault capture, at the CHECK->RESP edge when overflow|underflow:
  - fault_count increments and saturates at all-ones.
  - If fault_valid=0, load fault_id, fault_address (raw ptr+increment, WORD_WIDTH wrap) and fault_type, and set fault_valid=1.
  - If fault_valid=1, the record is kept (first fault wins).
- fault_clear clears fault_valid, fault_type and fault_count.
  - If fault_clear coincides with a capture, the capture wins: the new fault is recorded and the count becomes 1.
  - fault_clear outside FAULT clears the record only.
- Datapath arithmetic (tagged pointer fields: b_size=[63:58], l_size=[57:54]):
  - lower = ptr & (~0 << (b_size+4)).
  - upper = lower | (l_size << b_size).
  - last = (upper-1) & (~0 << access_type).
  - sum = ptr+increment.
  - If l_size==0: flag overflow when increment!=0; address = ptr.
  - Else: sum<lower gives underflow with address=lower; sum>last gives overflow with address=last. Overflow is evaluated last and takes priority.
  - All comparisons are unsigned, mod 2^WORD_WIDTH.
- Request-side rules:
  - Requesters must hold valid and operands stable until ready.
  - A valid dropped before grant is not served.
  - Non-granted requesters see ready=0.
- Reset mid-operation: the in-flight request is discarded and no response is issued; the requester must reissue it.

Decomposition:
- Package sma_pkg holds:
  - the FSM state enum;
  - tag field constants (BSIZE_WIDTH=6, LENGTH_WIDTH=4, field offsets);
  - the fault_type encoding (2'b10 overflow, 2'b01 underflow).
- One sub-module: the existing SMA_engine combinational datapath, instantiated once on the op registers.
- The round-robin picker stays inline.

Test Plan:
- Common operand P=0x1200_0000_0000_1000 (b_size=4, l_size=8). Bounds: lower=P, upper=P|0x80, last=P+0x78 for access_type=3.
- Pass: req0 sends P, inc=0x10, type=3 -> resp_valid 2 cycles after accept; addr=0x1200_0000_0000_1010; id=0; no flags; fault_count=0.
- Overflow with halt: cfg_halt_on_fault=1, req1 sends P, inc=0x100 -> addr=0x1200_0000_0000_1078, overflow=1.
  - fault_address=0x1200_0000_0000_1100, fault_type=2'b10, fault_count=1.
  - req_ready stays 0 while req0 is pending until fault_clear is pulsed; req0 is granted in the following IDLE cycle.
- Underflow: inc=0xFFFF_FFFF_FFFF_FFF0 -> addr=P, underflow=1. A second fault keeps the first fault record and fault_count=2.
- Arbitration: req0 and req1 held valid continuously with resp_ready=1 -> grants alternate 0,1,0,1; a response every 3 cycles.
- Backpressure and reset:
  - resp_ready=0 for 5 cycles -> response outputs stable and no new grant.
  - rst asserted while in CHECK -> all outputs 0 immediately and no response ever appears.
- l_size=0 pointer with inc=1 -> overflow=1, addr=ptr. Simultaneous fault_clear and capture -> fault_count=1, fault_valid=1.
